// File: rtl/scan_pkg.sv
// Shared types and helpers for the BCD digit scanner.
// Optional feature macro: SCAN_LZ_BLANK_EN (leading-zero blanking).
package scan_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Code the Encoder maps to all segments off
    localparam bcd_digit_t BLANK_CODE = 4'hF;

    // Upper bound on digits the one-hot helper can address
    localparam int MAX_DIGITS = 32;
    localparam int MAX_IDX_W  = $clog2(MAX_DIGITS);

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_DIGITS-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell counter and digit index for the scanner. cnt runs 0..DWELL-1 per
// digit; idx steps once per dwell and wraps at the frame boundary.
module scan_dwell_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          guard,
    output logic [$clog2(NUM_DIGITS)-1:0] idx,
    output logic [$clog2(DWELL)-1:0]      cnt,
    output logic                          frame_wrap
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Free-running dwell counter; index advances when the dwell expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign guard      = (cnt == '0);
    assign frame_wrap = (cnt == CNT_LAST) && (idx == IDX_LAST);

endmodule

// File: rtl/bcd_digit_scanner.sv
// Multiplexed BCD display scanner: shows one digit at a time with a one-hot
// select, a blank guard cycle per digit, and value updates that only take
// effect at frame boundaries.
// Optional feature macro: SCAN_LZ_BLANK_EN (leading-zero blanking).
module bcd_digit_scanner
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    output logic                      load_ready,
    output logic [3:0]                data,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(DWELL);

    logic                  guard;
    logic                  frame_wrap;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;

    bcd_digit_t [NUM_DIGITS-1:0] disp;
    bcd_digit_t [NUM_DIGITS-1:0] pend;
    logic                        pend_full;

    logic                  xfer;
    logic                  drain;
    bcd_digit_t            code;
    logic [MAX_DIGITS-1:0] sel_all;

    scan_dwell_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .DWELL      (DWELL)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .guard      (guard),
        .idx        (idx),
        .cnt        (cnt),
        .frame_wrap (frame_wrap)
    );

    assign xfer  = load_valid && load_ready;
    assign drain = frame_wrap && pend_full;

    // Single-entry pending buffer; disp only ever changes at a frame wrap.
    // xfer and drain are exclusive since load_ready mirrors !pend_full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp       <= '0;
            pend       <= '0;
            pend_full  <= 1'b0;
            load_ready <= 1'b1;
        end else if (drain) begin
            disp       <= pend;
            pend_full  <= 1'b0;
            load_ready <= 1'b1;
        end else if (xfer) begin
            pend       <= load_value;
            pend_full  <= 1'b1;
            load_ready <= 1'b0;
        end
    end

`ifdef SCAN_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] upper_zero;

    // upper_zero[k]: digits k..NUM_DIGITS-1 of disp are all zero
    always_comb begin
        upper_zero = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            upper_zero[k] = ((disp >> (4 * k)) == '0);
        end
    end

    // Selected digit, blanked when it is a leading zero (digit 0 always shown)
    always_comb begin
        code = disp[idx];
        if ((idx != '0) && upper_zero[idx]) begin
            code = BLANK_CODE;
        end
    end
`else
    // Selected digit, shown as-is including leading zeros
    always_comb begin
        code = disp[idx];
    end
`endif

    assign sel_all = onehot(MAX_IDX_W'(idx));

    // Registered outputs; data leads the select by the guard cycle so the
    // segments settle before the digit turns on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data        <= '0;
            digit_en    <= '0;
            frame_start <= 1'b0;
        end else begin
            data        <= code;
            digit_en    <= guard ? '0 : sel_all[NUM_DIGITS-1:0];
            frame_start <= (idx == '0) && (cnt == CNT_W'(1));
        end
    end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Scoreboard bench for bcd_digit_scanner (NUM_DIGITS=4, DWELL=4).
// Stimulus pushes the expected enabled-cycle sequence per frame; a monitor
// pops one entry every cycle digit_en is non-zero.
module tb_bcd_digit_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_value;
    logic        load_ready;
    logic [3:0]  data;
    logic [3:0]  digit_en;
    logic        frame_start;

    typedef struct {
        logic [3:0] data;
        logic [3:0] en;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

`ifdef SCAN_LZ_BLANK_EN
    localparam logic [15:0] SHOW_ZERO = 16'hFFF0;
    localparam logic [15:0] SHOW_0050 = 16'hFF50;
`else
    localparam logic [15:0] SHOW_ZERO = 16'h0000;
    localparam logic [15:0] SHOW_0050 = 16'h0050;
`endif

    bcd_digit_scanner #(
        .NUM_DIGITS (4),
        .DWELL      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_value  (load_value),
        .load_ready  (load_ready),
        .data        (data),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Cycles since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Expected items for one frame: each digit gets 3 enabled cycles
    task automatic push_frame(input logic [15:0] shown, input int nitems);
        exp_t e;
        int   n = 0;
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 3; r++) begin
                if (n < nitems) begin
                    e.data = shown[4*d +: 4];
                    e.en   = 4'b0001 << d;
                    e.fs   = (d == 0) && (r == 0);
                    q.push_back(e);
                end
                n++;
            end
        end
    endtask

    // Monitor: compare every presented digit against the scoreboard
    always @(negedge clk) begin
        if (mon_en && digit_en != 4'b0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data=%0h en=%b, none expected (cyc %0d)",
                         data, digit_en, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("scan_data", {28'b0, data}, {28'b0, e.data});
                check("scan_en", {28'b0, digit_en}, {28'b0, e.en});
                check("scan_frame_start", {31'b0, frame_start}, {31'b0, e.fs});
            end
        end else if (mon_en && frame_start) begin
            check("frame_start_in_guard", {31'b0, frame_start}, 32'd0);
        end
    end

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_value = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_data", {28'b0, data}, 32'd0);
        check("rst_en", {28'b0, digit_en}, 32'd0);
        check("rst_ready", {31'b0, load_ready}, 32'd1);

        push_frame(SHOW_ZERO, 12);
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Frame 0: reset value; load 4321
        wait_to(3);
        load_valid = 1'b1; load_value = 16'h4321;
        wait_to(4);
        load_valid = 1'b0;
        check("ready_after_xfer", {31'b0, load_ready}, 32'd0);

        // Frame 1: 4321 in scan order; queue 1234
        wait_to(16);
        push_frame(16'h4321, 12);
        wait_to(20);
        load_valid = 1'b1; load_value = 16'h1234;
        wait_to(21);
        load_valid = 1'b0;

        // Frame 2: 1234; a mid-frame 9999 must not disturb digits 2,3
        wait_to(32);
        push_frame(16'h1234, 12);
        wait_to(38);
        load_valid = 1'b1; load_value = 16'h9999;
        wait_to(39);
        load_valid = 1'b0;

        // Frame 3: 9999; backpressure with valid held
        wait_to(48);
        push_frame(16'h9999, 12);
        wait_to(50);
        check("bp_ready_before", {31'b0, load_ready}, 32'd1);
        load_valid = 1'b1; load_value = 16'h1111;
        wait_to(51);
        check("bp_ready_dropped", {31'b0, load_ready}, 32'd0);
        load_value = 16'h2222;
        wait_to(63);
        check("bp_ready_at_boundary", {31'b0, load_ready}, 32'd0);

        // Frame 4: 1111; ready back one cycle after the boundary
        wait_to(64);
        push_frame(16'h1111, 12);
        check("bp_ready_rises", {31'b0, load_ready}, 32'd1);
        wait_to(65);
        load_valid = 1'b0;
        check("bp_second_taken", {31'b0, load_ready}, 32'd0);

        // Frame 5: 2222; queue 0050
        wait_to(80);
        push_frame(16'h2222, 12);
        wait_to(82);
        load_valid = 1'b1; load_value = 16'h0050;
        wait_to(83);
        load_valid = 1'b0;

        // Frame 6: 0050, cut short by reset during digit 2 with 7777 pending
        wait_to(96);
        push_frame(SHOW_0050, 8);
        wait_to(98);
        load_valid = 1'b1; load_value = 16'h7777;
        wait_to(99);
        load_valid = 1'b0;
        wait_to(107);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_data", {28'b0, data}, 32'd0);
        check("midrst_en", {28'b0, digit_en}, 32'd0);
        check("midrst_fs", {31'b0, frame_start}, 32'd0);
        check("midrst_ready", {31'b0, load_ready}, 32'd1);
        check("midrst_queue_drained", q.size(), 32'd0);
        repeat (3) @(negedge clk);

        // After release: two frames of zeros; pending 7777 is gone
        push_frame(SHOW_ZERO, 12);
        rst_n = 1'b1;
        wait_to(16);
        push_frame(SHOW_ZERO, 12);
        wait_to(33);
        mon_en = 1'b0;
        check("final_queue_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
